// File: rtl/hack_alu_seq.sv
// Sequential Hack ALU: zx/nx/zy/ny/f/no function set plus SHL, SAR and shift-add MUL.
// Latency: 1 cycle from accept to out_valid for HACK/SHL/SAR, WIDTH+1 cycles for MUL.
// Backpressure: result is held stable in DONE until out_ready; in_ready is low in BUSY and DONE.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready   request handshake carrying x, y, ctrl {zx,nx,zy,ny,f,no}, op
//   op                    00 HACK, 01 SHL, 10 SAR, 11 MUL
//   out_valid / out_ready result handshake carrying out, zr, ng, ov (all registered)
// Optional: define HACK_ALU_OVF_EN to drive ov with the signed overflow of the HACK add;
//           otherwise ov is tied to 0.

module hack_alu_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [5:0]       ctrl,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zr,
   output logic             ng,
   output logic             ov
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [1:0] OP_HACK = 2'b00;
   localparam logic [1:0] OP_SHL  = 2'b01;
   localparam logic [1:0] OP_SAR  = 2'b10;
   localparam logic [1:0] OP_MUL  = 2'b11;

   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [SHW-1:0]   r_cnt;
   logic             r_no;
   logic [WIDTH-1:0] r_out;
   logic             r_zr;
   logic             r_ng;
   logic             r_out_valid;

   logic             w_zx, w_nx, w_zy, w_ny, w_f, w_no;
   logic [WIDTH-1:0] w_xz, w_yz, w_xp, w_yp;
   logic [SHW-1:0]   w_shamt;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_core;
   logic [WIDTH-1:0] w_fast;
   logic [WIDTH-1:0] w_acc_nxt;
   logic [WIDTH-1:0] w_res;
   logic             w_ld_res;

   assign {w_zx, w_nx, w_zy, w_ny, w_f, w_no} = ctrl;

   assign w_xz    = w_zx ? '0 : x;
   assign w_yz    = w_zy ? '0 : y;
   assign w_xp    = w_nx ? ~w_xz : w_xz;
   assign w_yp    = w_ny ? ~w_yz : w_yz;
   // Only the low SHW bits of yp steer the shifter; upper bits are ignored.
   assign w_shamt = w_yp[SHW-1:0];
   assign w_sum   = w_xp + w_yp;

   // Single-cycle ops evaluate straight from the inputs on the accept edge.
   always_comb begin
      w_core = w_f ? w_sum : (w_xp & w_yp);
      case (op)
         OP_SHL:  w_core = w_xp << w_shamt;
         OP_SAR:  w_core = $signed(w_xp) >>> w_shamt;
         default: w_core = w_f ? w_sum : (w_xp & w_yp);
      endcase
   end

   assign w_fast    = w_no ? ~w_core : w_core;
   assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      w_ld_res    = 1'b0;
      w_res       = w_fast;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (op == OP_MUL) begin
                  w_state_nxt = S_BUSY;
               end else begin
                  w_state_nxt = S_DONE;
                  w_ld_res    = 1'b1;
               end
            end
         end
         S_BUSY: begin
            // Last iteration: the final partial sum goes straight to the out register.
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = S_DONE;
               w_ld_res    = 1'b1;
               w_res       = r_no ? ~w_acc_nxt : w_acc_nxt;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_cnt       <= '0;
         r_no        <= 1'b0;
         r_out       <= '0;
         r_zr        <= 1'b0;
         r_ng        <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         if (r_state == S_IDLE && in_valid && op == OP_MUL) begin
            r_acc    <= '0;
            r_mcand  <= w_xp;
            r_mplier <= w_yp;
            r_cnt    <= '0;
            r_no     <= w_no;
         end else if (r_state == S_BUSY) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + SHW'(1);
         end

         if (w_ld_res) begin
            r_out       <= w_res;
            r_zr        <= (w_res == '0);
            r_ng        <= w_res[WIDTH-1];
            r_out_valid <= 1'b1;
         end else if (r_state == S_DONE && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

`ifdef HACK_ALU_OVF_EN
   logic r_ov;
   logic w_ov_hack;

   // Overflow of the raw add, before the optional output inversion.
   assign w_ov_hack = (op == OP_HACK) && w_f &&
                      (w_xp[WIDTH-1] == w_yp[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != w_xp[WIDTH-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ov <= 1'b0;
      end else if (w_ld_res) begin
         r_ov <= (r_state == S_IDLE) && w_ov_hack;
      end
   end

   assign ov = r_ov;
`else
   assign ov = 1'b0;
`endif

   assign out       = r_out;
   assign zr        = r_zr;
   assign ng        = r_ng;
   assign out_valid = r_out_valid;

endmodule

// File: doc/hack_alu_seq.md
Name: hack_alu_seq

Overview:
- Parametrised, sequential successor to the combinational Hack ALU.
- Keeps the zx/nx/zy/ny/f/no function set and adds three ops: logical shift left, arithmetic shift right and iterative shift-add multiply.
- Adds a valid/ready handshake on input and output, with registered results and flags.
- Sits between the CPU datapath and a multi-cycle execute stage of the extended Hack core.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 4).
- SHW, $clog2(WIDTH), localparam (derived, not overridable): shift-amount width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and controls valid.
- in_ready  out  1  block can accept a request.
- x  in  WIDTH  operand x.
- y  in  WIDTH  operand y.
- ctrl  in  6  {zx,nx,zy,ny,f,no}, Hack ALU semantics.
- op  in  2  00 HACK, 01 SHL, 10 SAR, 11 MUL.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out  out  WIDTH  registered result.
- zr  out  1  out == 0.
- ng  out  1  out[WIDTH-1].
- ov  out  1  signed overflow (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - out, zr, ng, ov, out_valid = 0.
  - in_ready = 1 once the block is out of reset.
- Accept: a request is taken on the rising edge where in_valid && in_ready. x, y, ctrl and op are captured; later input changes are ignored.
- Preprocessing (all ops):
  - xp = nx ? ~(zx?0:x) : (zx?0:x).
  - yp is formed the same way from zy/ny.
- Core result r:
  - HACK: f ? xp+yp : xp&yp, truncated to WIDTH.
  - SHL: xp << yp[SHW-1:0], zero-fill.
  - SAR: xp >>> yp[SHW-1:0], sign-fill from xp[WIDTH-1].
  - MUL: low WIDTH bits of xp*yp, unsigned (identical to the signed low half).
- Final result: out = no ? ~r : r. zr and ng are derived from the final out and registered with it.
- State machine:
  - IDLE: in_ready=1. On accept with op!=MUL, compute r and go to DONE. On accept with op=MUL, load acc=0, mcand=xp, mplier=yp, cnt=0, and go to BUSY.
  - BUSY: in_ready=0. Each cycle: if mplier[0], acc+=mcand; then mcand<<=1, mplier>>=1, cnt++. After WIDTH iterations (cnt==WIDTH-1 on that edge), register the result and go to DONE.
  - DONE: out_valid=1, in_ready=0. On out_ready=1, clear out_valid and go to IDLE.
- Latency, counted from the accept edge to out_valid high:
  - 1 cycle for HACK/SHL/SAR.
  - WIDTH+1 cycles for MUL.
- Throughput: at most one request per 2 cycles. No overlap: in_ready is low in BUSY and DONE.
- Backpressure: while out_valid=1 and out_ready=0, out/zr/ng/ov hold stable indefinitely.
- The out register keeps the previous result while IDLE/BUSY. out_valid is the only qualifier.
- Shift amount uses only the low SHW bits of yp. Shift by 0 returns xp unchanged.
- Reset asserted mid-BUSY aborts the operation. No result is produced; the block returns to IDLE with all outputs zero.
- in_valid while in_ready=0 is ignored; the requester must hold the request until accepted.

Optional Feature:
- Macro: HACK_ALU_OVF_EN.
- Defined: ov is set only for op=HACK with f=1. It is the signed overflow of xp+yp, i.e. xp, yp same sign and r sign differs, evaluated before `no`. For all other ops, ov=0. ov is registered with out.
- Undefined: the ov port remains but is tied to 0, and no overflow logic is synthesised.

Test Plan (WIDTH=16):
- HACK x=5, y=7, ctrl=000010, op=00 -> one cycle after accept: out=0x000C, zr=0, ng=0, out_valid=1.
- HACK x-y: x=3, y=5, ctrl=010011 (nx, f, no) -> out=0xFFFE, ng=1, zr=0. Then x=5, y=5 same ctrl -> out=0x0000, zr=1.
- SAR x=0x8001, y=4, ctrl=000000, op=10 -> out=0xF800. SHL same operands, op=01 -> out=0x0010.
- MUL x=300, y=300, op=11, ctrl=000000 -> in_ready=0 for 17 cycles; out_valid at accept+17; out=0x5F90.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles after a result -> out stable and in_ready=0. A new in_valid is not accepted until the cycle after out_ready=1.
  - Assert rst_n=0 at cycle 5 of a MUL -> out_valid=0, out=0, in_ready=1 after release.
- With HACK_ALU_OVF_EN: x=0x7FFF, y=0x0001, ctrl=000010 -> out=0x8000, ng=1, ov=1. x=0x0001, y=0x0001 -> ov=0. Without the macro, ov=0 in both cases.
